// File: rtl/pdp8l_pkg.sv
// pdp8l_pkg: shared FSM state encoding, IOT major opcode and IOP bit helpers for PDP-8/L I/O devices
package pdp8l_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  localparam logic [2:0] IOT_MAJOR = 3'o6;
  // Index (0=IOP1, 1=IOP2, 2=IOP4) of the last IOP pulse an instruction's low bits ask for.
  function automatic logic [1:0] hi_bit(input logic [2:0] b);
    return b[2] ? 2'd2 : b[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pdp8l_sync_filter.sv
// pdp8l_sync_filter: 2-flop synchronizer plus FILTER-cycle glitch filter producing accepted rise/fall strobes
// Ports:
//   CLOCK, RESET  fabric clock, synchronous active-high reset
//   hold          while high, a qualified level change is kept waiting instead of being accepted
//   async_in      asynchronous input level
//   rise, fall    one-cycle strobes in the cycle a level change is accepted
module pdp8l_sync_filter #(
  parameter int FILTER = 3
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic hold,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  localparam int CW = FILTER > 1 ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);
  logic s1, s2, lvl, acc;
  logic [CW-1:0] cnt;
  // A change is accepted on its FILTER-th stable cycle; under hold the counter parks at CMAX
  // so the change is taken the very first cycle hold drops.
  assign acc  = (s2 != lvl) && cnt == CMAX && !hold;
  assign rise = acc && s2;
  assign fall = acc && !s2;
  always_ff @(posedge CLOCK)
    if (RESET) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= async_in;
      s2  <= s1;
      lvl <= acc ? s2 : lvl;
      cnt <= (s2 == lvl || acc) ? '0 : cnt == CMAX ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/pdp8l_iop_framer.sv
// pdp8l_iop_framer: frames PDP-8/L IOP1/2/4 pulses into one CSTEP-aligned iopstart/iopstop pair per IOT
// Ports:
//   CLOCK, RESET       fabric clock, synchronous active-high reset
//   CSTEP              clock-step enable; iopstart/iopstop only appear on CSTEP cycles
//   iop1_a/iop2_a/iop4_a  asynchronous IOP pulses from the 8/L bus
//   membuf, acbus      current instruction and accumulator, stable while IOPs are active
//   iopstart, iopstop  one-cycle frame boundary pulses
//   ioopcode, cputodev instruction and AC latched at frame start
//   busy               high from the accepted first edge until iopstop
//   spurious_cnt       saturating count of ignored pulses and timeouts
module pdp8l_iop_framer
  import pdp8l_pkg::*;
#(
  parameter int FILTER  = 3,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        iop1_a,
  input  logic        iop2_a,
  input  logic        iop4_a,
  input  logic [11:0] membuf,
  input  logic [11:0] acbus,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  output logic        busy,
  output logic [7:0]  spurious_cnt
);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  state_t state, nxt;
  logic [2:0] iop_a, rise, fall;
  logic [1:0] rsel, cur, last;
  logic [TW-1:0] tcnt;
  logic hold, any_rise, any_edge, framed, qual, gap_ok, cur_fall, timeout, spur_inc, start_pend;
  assign iop_a = {iop4_a, iop2_a, iop1_a};
  // Edges arriving while a stop is still pending wait in the filters so frames never overlap.
  assign hold = state == DONE;
  for (genvar i = 0; i < 3; i++) begin : g_iop
    pdp8l_sync_filter #(.FILTER(FILTER)) u_filter (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .hold    (hold),
      .async_in(iop_a[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end
  // Simultaneous rises are resolved toward the lowest IOP; the others are dropped.
  assign rsel     = rise[0] ? 2'd0 : rise[1] ? 2'd1 : 2'd2;
  assign any_rise = |rise;
  assign any_edge = |(rise | fall);
  assign framed   = state == ACTIVE || state == GAP;
  assign qual     = any_rise && membuf[11:9] == IOT_MAJOR && membuf[rsel];
  assign gap_ok   = any_rise && rsel > cur && ioopcode[rsel];
  assign cur_fall = fall[cur];
  assign timeout  = framed && !any_edge && tcnt == TMAX;
  assign spur_inc = (state == IDLE && any_rise && !qual) || (state == GAP && any_rise && !gap_ok) || timeout;
  always_ff @(posedge CLOCK)
    if (RESET) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = qual ? ACTIVE : IDLE;
      ACTIVE:  nxt = cur_fall ? (cur == last ? DONE : GAP) : timeout ? DONE : ACTIVE;
      GAP:     nxt = gap_ok ? ACTIVE : timeout ? DONE : GAP;
      default: nxt = iopstop ? IDLE : DONE;
    endcase
  end
  // DONE doubles as the stop-pending flag; a start still owed is always emitted first.
  always_comb begin
    iopstart = CSTEP && start_pend;
    iopstop  = CSTEP && state == DONE && !start_pend;
    busy     = state != IDLE && !iopstop;
  end
  always_ff @(posedge CLOCK)
    if (RESET) begin
      start_pend   <= 1'b0;
      ioopcode     <= '0;
      cputodev     <= '0;
      cur          <= '0;
      last         <= '0;
      tcnt         <= '0;
      spurious_cnt <= '0;
    end else begin
      if (state == IDLE && qual) begin
        ioopcode <= membuf;
        cputodev <= acbus;
        last     <= hi_bit(membuf[2:0]);
      end
      cur          <= (state == IDLE && qual) || (state == GAP && gap_ok) ? rsel : cur;
      start_pend   <= (state == IDLE && qual) || (start_pend && !CSTEP);
      tcnt         <= (any_edge || !framed) ? '0 : tcnt + 1'b1;
      spurious_cnt <= spur_inc && spurious_cnt != 8'hff ? spurious_cnt + 1'b1 : spurious_cnt;
    end
endmodule

// File: tb/tb_pdp8l_iop_framer.sv
// tb_pdp8l_iop_framer: directed self-checking bench for pdp8l_iop_framer
module tb_pdp8l_iop_framer;
  logic CLOCK = 0, RESET = 1, CSTEP = 1, iop1_a = 0, iop2_a = 0, iop4_a = 0;
  logic [11:0] membuf = 0, acbus = 0;
  logic iopstart, iopstop, busy;
  logic [11:0] ioopcode, cputodev;
  logic [7:0] spurious_cnt;
  int cyc = 0, nstart = 0, nstop = 0, t_start = -1, t_stop = -1;
  int nchk = 0, nerr = 0;
  int s, p, t0, t1, c;
  pdp8l_iop_framer dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP),
    .iop1_a(iop1_a), .iop2_a(iop2_a), .iop4_a(iop4_a),
    .membuf(membuf), .acbus(acbus),
    .iopstart(iopstart), .iopstop(iopstop),
    .ioopcode(ioopcode), .cputodev(cputodev),
    .busy(busy), .spurious_cnt(spurious_cnt)
  );
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;
  always @(negedge CLOCK) begin
    if (iopstart) begin nstart++; t_start = cyc; end
    if (iopstop) begin nstop++; t_stop = cyc; end
  end
  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask
  task automatic do_reset;
    RESET = 1; CSTEP = 1; iop1_a = 0; iop2_a = 0; iop4_a = 0;
    step(3);
    RESET = 0;
    step(1);
    s = nstart; p = nstop;
  endtask
  initial begin
    do_reset;
    chk("rst_iopstart", 32'(iopstart), 0);
    chk("rst_iopstop", 32'(iopstop), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ioopcode", 32'(ioopcode), 0);
    chk("rst_cputodev", 32'(cputodev), 0);
    chk("rst_spurious", 32'(spurious_cnt), 0);
    // single-bit IOT
    membuf = 12'o6741; acbus = 12'o1234; t0 = cyc; iop1_a = 1;
    step(10);
    chk("t1_busy_mid", 32'(busy), 1);
    step(10);
    iop1_a = 0;
    step(30);
    chk("t1_nstart", nstart - s, 1);
    chk("t1_start_cyc", t_start, t0 + 5);
    chk("t1_nstop", nstop - p, 1);
    chk("t1_stop_cyc", t_stop, t0 + 25);
    chk("t1_ioopcode", 32'(ioopcode), 32'o6741);
    chk("t1_cputodev", 32'(cputodev), 32'o1234);
    chk("t1_busy_end", 32'(busy), 0);
    // two-pulse IOT framed once
    do_reset;
    membuf = 12'o6743; acbus = 12'o0055; t0 = cyc; iop1_a = 1;
    step(10); iop1_a = 0; step(30);
    chk("t2_busy_gap", 32'(busy), 1);
    chk("t2_nstop_gap", nstop - p, 0);
    iop2_a = 1; step(10); t1 = cyc; iop2_a = 0; step(20);
    chk("t2_nstart", nstart - s, 1);
    chk("t2_start_cyc", t_start, t0 + 5);
    chk("t2_nstop", nstop - p, 1);
    chk("t2_stop_cyc", t_stop, t1 + 5);
    chk("t2_ioopcode", 32'(ioopcode), 32'o6743);
    // 2-cycle glitch rejected
    do_reset;
    membuf = 12'o6741; iop1_a = 1; step(2); iop1_a = 0; step(20);
    chk("t3_nstart", nstart - s, 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_spurious", 32'(spurious_cnt), 0);
    // stuck IOP2 forces a timeout stop
    do_reset;
    membuf = 12'o6742; t0 = cyc; iop2_a = 1; step(1020);
    chk("t4_nstart", nstart - s, 1);
    chk("t4_nstop", nstop - p, 1);
    chk("t4_stop_cyc", t_stop, t0 + 1005);
    chk("t4_spurious", 32'(spurious_cnt), 1);
    iop2_a = 0; step(10);
    chk("t4_spurious_after", 32'(spurious_cnt), 1);
    chk("t4_busy", 32'(busy), 0);
    // CSTEP low for a whole frame
    do_reset;
    CSTEP = 0; membuf = 12'o6741; iop1_a = 1; step(10); iop1_a = 0; step(20);
    chk("t5_nstart_held", nstart - s, 0);
    chk("t5_nstop_held", nstop - p, 0);
    chk("t5_busy_held", 32'(busy), 1);
    CSTEP = 1; c = cyc; step(1); CSTEP = 0; step(1); CSTEP = 1; step(5);
    chk("t5_nstart", nstart - s, 1);
    chk("t5_start_cyc", t_start, c);
    chk("t5_nstop", nstop - p, 1);
    chk("t5_stop_cyc", t_stop, c + 2);
    // non-IOT rise, then reset mid-frame
    do_reset;
    membuf = 12'o5001; iop1_a = 1; step(10); iop1_a = 0; step(20);
    chk("t6_spurious_major", 32'(spurious_cnt), 1);
    chk("t6_nstart_major", nstart - s, 0);
    membuf = 12'o6741; acbus = 12'o7777; iop1_a = 1; step(10);
    chk("t6_busy_active", 32'(busy), 1);
    RESET = 1; iop1_a = 0; step(1);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ioopcode", 32'(ioopcode), 0);
    chk("t6_rst_cputodev", 32'(cputodev), 0);
    chk("t6_rst_spurious", 32'(spurious_cnt), 0);
    chk("t6_rst_iopstop", 32'(iopstop), 0);
    RESET = 0; step(40);
    chk("t6_nstop", nstop - p, 0);
    chk("t6_busy_after", 32'(busy), 0);
    // unset bit in gap is ignored, IOP4 completes the frame
    do_reset;
    membuf = 12'o6745; iop1_a = 1; step(10); iop1_a = 0; step(20);
    iop2_a = 1; step(10); iop2_a = 0; step(20);
    chk("t7_spurious", 32'(spurious_cnt), 1);
    chk("t7_busy_gap", 32'(busy), 1);
    iop4_a = 1; step(10); t1 = cyc; iop4_a = 0; step(20);
    chk("t7_nstart", nstart - s, 1);
    chk("t7_nstop", nstop - p, 1);
    chk("t7_stop_cyc", t_stop, t1 + 5);
    // new rise held while the previous stop is pending
    do_reset;
    CSTEP = 0; membuf = 12'o6741; acbus = 12'o1111; iop1_a = 1; step(10); iop1_a = 0; step(20);
    acbus = 12'o2222; iop1_a = 1; step(20);
    chk("t8_nstart_held", nstart - s, 0);
    CSTEP = 1; c = cyc; step(10);
    chk("t8_nstart", nstart - s, 2);
    chk("t8_start2_cyc", t_start, c + 3);
    chk("t8_nstop", nstop - p, 1);
    chk("t8_stop1_cyc", t_stop, c + 1);
    chk("t8_cputodev", 32'(cputodev), 32'o2222);
    chk("t8_busy", 32'(busy), 1);
    iop1_a = 0; step(20);
    chk("t8_nstop_end", nstop - p, 2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
